// File: rtl/mul_arb_pkg.sv
// ---------------------------------------------------------------------------
// mul_arb_pkg
// Shared definitions for the multiplier-sharing arbiter slice:
//   - arb_state_e : controller states (IDLE, RUN, RSP)
//   - DEF_*       : default parameter values used by mul_share_arb
//   - calc_idw    : width of a requester index, never less than one bit
// ---------------------------------------------------------------------------
package mul_arb_pkg;

    // Controller states. IDLE arbitrates, RUN owns the multiplier, RSP holds
    // the result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RSP  = 2'd2
    } arb_state_e;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_W       = 256;
    localparam int DEF_TIMEOUT = 512;

    // A two-requester system still needs a one-bit index, so clamp at 1.
    function automatic int calc_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant logic. The search starts at the
// requester named by ptr and wraps upward; the first active request wins.
// The pointer register itself lives in the parent so that it only advances
// when a grant is actually accepted.
//
// Ports:
//   req        in   N     request vector
//   ptr        in   IDW   highest-priority requester index (must be < N)
//   grant      out  N     one-hot grant (all zero when no request)
//   grant_idx  out  IDW   encoded index of the granted requester
//   grant_vld  out  1     at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           grant_vld
);

    // Walk the requesters in priority order starting at ptr. Once a winner
    // is found, grant_vld blocks any later candidate from overriding it.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_vld && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// ---------------------------------------------------------------------------
// mul_share_arb
// Shares one shift-add multiplier among N_REQ requesters. Requests are granted
// round-robin, one multiply is in flight at a time, and the product is
// returned tagged with the requester index. A watchdog turns a multiplier that
// never finishes into an error response instead of a hang.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset (shared with multiplier)
//   req_valid  in   N_REQ    per-requester operand valid
//   req_ready  out  N_REQ    per-requester accept, at most one bit high
//   req_a      in   N_REQ*W  operand A, requester k at [k*W +: W]
//   req_b      in   N_REQ*W  operand B, same packing
//   rsp_valid  out  1        result valid
//   rsp_ready  in   1        result consumer ready
//   rsp_id     out  IDW      requester index of the result
//   rsp_y      out  2*W      product (zero on error)
//   rsp_err    out  1        watchdog expired
//   mul_start  out  1        multiplier start, level held for the whole operation
//   mul_ain    out  W        multiplier operand A
//   mul_bin    out  W        multiplier operand B
//   mul_yout   in   2*W      multiplier product
//   mul_done   in   1        multiplier completion pulse
// ---------------------------------------------------------------------------
module mul_share_arb
    import mul_arb_pkg::*;
#(
    parameter  int N_REQ   = DEF_N_REQ,
    parameter  int W       = DEF_W,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int IDW     = calc_idw(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [2*W-1:0]     rsp_y,
    output logic               rsp_err,
    output logic               mul_start,
    output logic [W-1:0]       mul_ain,
    output logic [W-1:0]       mul_bin,
    input  logic [2*W-1:0]     mul_yout,
    input  logic               mul_done
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    arb_state_e       state_q,     state_d;
    logic [IDW-1:0]   ptr_q,       ptr_d;
    logic [IDW-1:0]   id_q,        id_d;
    logic [W-1:0]     ain_q,       ain_d;
    logic [W-1:0]     bin_q,       bin_d;
    logic [2*W-1:0]   y_q,         y_d;
    logic             err_q,       err_d;
    logic [WDW-1:0]   wd_q,        wd_d;
    logic             mul_start_q, mul_start_d;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_vld;
    logic             accept;

    rr_arbiter #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // Next-state and output logic. req_ready is only offered in IDLE, and is
    // also held low while reset is asserted so no requester ever sees an
    // accept during reset. mul_start is registered: it rises on the accept
    // edge and falls on the edge that leaves RUN, so the multiplier always
    // sees at least one low cycle (RSP) between operations.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        ain_d       = ain_q;
        bin_d       = bin_q;
        y_d         = y_q;
        err_d       = err_q;
        wd_d        = wd_q;
        mul_start_d = mul_start_q;
        req_ready   = '0;
        accept      = 1'b0;

        case (state_q)
            IDLE: begin
                if (rst_n) begin
                    req_ready = grant;
                end
                accept = grant_vld && |(req_valid & req_ready);
                if (accept) begin
                    ain_d       = req_a[int'(grant_idx)*W +: W];
                    bin_d       = req_b[int'(grant_idx)*W +: W];
                    id_d        = grant_idx;
                    ptr_d       = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
                    wd_d        = '0;
                    mul_start_d = 1'b1;
                    state_d     = RUN;
                end
            end

            RUN: begin
                wd_d = wd_q + WDW'(1);
                // A completion in the same cycle as watchdog expiry is a
                // real result, so mul_done is tested first.
                if (mul_done) begin
                    y_d         = mul_yout;
                    err_d       = 1'b0;
                    mul_start_d = 1'b0;
                    state_d     = RSP;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    y_d         = '0;
                    err_d       = 1'b1;
                    mul_start_d = 1'b0;
                    state_d     = RSP;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                mul_start_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset abandons any in-flight request
    // without producing a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            ain_q       <= '0;
            bin_q       <= '0;
            y_q         <= '0;
            err_q       <= 1'b0;
            wd_q        <= '0;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            ain_q       <= ain_d;
            bin_q       <= bin_d;
            y_q         <= y_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
            mul_start_q <= mul_start_d;
        end
    end

    assign rsp_valid = (state_q == RSP);
    assign rsp_id    = id_q;
    assign rsp_y     = y_q;
    assign rsp_err   = err_q;
    assign mul_start = mul_start_q;
    assign mul_ain   = ain_q;
    assign mul_bin   = bin_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// ---------------------------------------------------------------------------
// tb_mul_share_arb
// Drives mul_share_arb (N_REQ=4, W=256) against a behavioural shift-add
// multiplier that finishes MUL_LAT cycles after start, or never in stub mode.
// Expected grants come from a round-robin pointer model and expected products
// from plain wide multiplication.
// ---------------------------------------------------------------------------
module tb_mul_share_arb;

    localparam int N       = 4;
    localparam int W       = 256;
    localparam int TIMEOUT = 512;
    localparam int MUL_LAT = W;
    localparam int IDW     = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [2*W-1:0]   rsp_y;
    logic             rsp_err;
    logic             mul_start;
    logic [W-1:0]     mul_ain;
    logic [W-1:0]     mul_bin;
    logic [2*W-1:0]   mul_yout;
    logic             mul_done;

    logic [W-1:0]     opa [N];
    logic [W-1:0]     opb [N];
    logic             stub_mode;
    logic             spurious_done;
    logic             m_done;
    int               m_cnt;

    int               errors;
    int               checks;
    int               model_ptr;

    always #5 clk = ~clk;

    assign req_a    = {opa[3], opa[2], opa[1], opa[0]};
    assign req_b    = {opb[3], opb[2], opb[1], opb[0]};
    assign mul_done = m_done | spurious_done;

    mul_share_arb #(
        .N_REQ   (N),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err),
        .mul_start (mul_start),
        .mul_ain   (mul_ain),
        .mul_bin   (mul_bin),
        .mul_yout  (mul_yout),
        .mul_done  (mul_done)
    );

    // Behavioural multiplier: counts cycles while start is high and pulses
    // done once with the full product; clears whenever start drops.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    <= 0;
            m_done   <= 1'b0;
            mul_yout <= '0;
        end else if (!mul_start) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt < MUL_LAT) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == MUL_LAT - 1 && !stub_mode) begin
                    m_done   <= 1'b1;
                    mul_yout <= {{W{1'b0}}, mul_ain} * {{W{1'b0}}, mul_bin};
                end
            end
        end
    end

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W / 32; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    // Round-robin rule: first valid requester at or after the pointer.
    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) begin
                return (p + i) % N;
            end
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction, entered and left on a falling edge: offer the
    // valid mask, confirm the grant, follow the operation to its response,
    // optionally stall the consumer, then complete the handshake.
    task automatic applyStimulus(input logic [N-1:0] valid, input bit keep,
                                 input int stall, input bit expect_err);
        int           k;
        int           cyc;
        logic [2*W-1:0] exp_y;
        k = model_grant(valid, model_ptr);
        exp_y = expect_err ? '0 : {{W{1'b0}}, opa[k]} * {{W{1'b0}}, opb[k]};
        req_valid = valid;
        #1;
        checkOutput("req_ready_grant", req_ready, (N'(1) << k));
        @(posedge clk);
        model_ptr = (k + 1) % N;
        @(negedge clk);
        if (!keep) begin
            req_valid[k] = 1'b0;
        end
        checkOutput("mul_start_run", mul_start, 1);
        checkOutput("mul_ain", mul_ain, opa[k]);
        checkOutput("mul_bin", mul_bin, opb[k]);
        checkOutput("req_ready_run", req_ready, 0);
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < TIMEOUT + 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("rsp_latency", cyc, expect_err ? TIMEOUT : MUL_LAT + 1);
        checkOutput("rsp_id", rsp_id, k);
        checkOutput("rsp_y", rsp_y, exp_y);
        checkOutput("rsp_err", rsp_err, expect_err);
        checkOutput("mul_start_rsp", mul_start, 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("stall_valid", rsp_valid, 1);
            checkOutput("stall_y", rsp_y, exp_y);
            checkOutput("stall_id", rsp_id, k);
            checkOutput("stall_ready", req_ready, 0);
            checkOutput("stall_start", mul_start, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_drop", rsp_valid, 0);
        checkOutput("mul_start_idle", mul_start, 0);
        if (!keep) begin
            req_valid = '0;
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        model_ptr     = 0;
        req_valid     = '0;
        rsp_ready     = 1'b0;
        stub_mode     = 1'b0;
        spurious_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end

        // Reset state, including no accept while reset is asserted.
        repeat (3) @(negedge clk);
        req_valid = 4'hF;
        #1;
        checkOutput("reset_req_ready", req_ready, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_mul_start", mul_start, 0);
        checkOutput("reset_mul_ain", mul_ain, 0);
        checkOutput("reset_rsp_y", rsp_y, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        checkOutput("reset_rsp_id", rsp_id, 0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single request from requester 2");
        opa[2] = 256'd3;
        opb[2] = 256'd5;
        applyStimulus(4'b0100, 1'b0, 0, 1'b0);
        checkOutput("single_y_15", rsp_y, 512'd15);

        $display("[TB] maximum operands");
        opa[3] = '1;
        opb[3] = '1;
        applyStimulus(4'b1000, 1'b0, 0, 1'b0);
        checkOutput("max_y_formula", rsp_y, 512'd1 - (512'd1 << 257));

        $display("[TB] all requesters continuously valid");
        for (int i = 0; i < N; i++) begin
            opa[i] = rand256();
            opb[i] = rand256();
        end
        for (int g = 0; g < 4; g++) begin
            applyStimulus(4'hF, 1'b1, 0, 1'b0);
        end
        applyStimulus(4'hF, 1'b0, 0, 1'b0);

        $display("[TB] consumer stall of 20 cycles");
        opa[1] = rand256();
        opb[1] = rand256();
        applyStimulus(4'b0010, 1'b0, 20, 1'b0);

        $display("[TB] done pulse outside RUN");
        spurious_done = 1'b1;
        @(negedge clk);
        spurious_done = 1'b0;
        checkOutput("spurious_rsp_valid", rsp_valid, 0);
        checkOutput("spurious_mul_start", mul_start, 0);
        @(negedge clk);
        checkOutput("spurious_rsp_valid2", rsp_valid, 0);

        $display("[TB] watchdog expiry with stub multiplier");
        stub_mode = 1'b1;
        applyStimulus(4'b0001, 1'b0, 2, 1'b1);
        stub_mode = 1'b0;

        $display("[TB] randomized transactions");
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                opa[i] = rand256();
                opb[i] = rand256();
            end
            applyStimulus(4'($urandom_range(1, 15)), 1'b0, $urandom_range(0, 3), 1'b0);
        end

        $display("[TB] reset in the middle of RUN");
        opa[2] = rand256();
        opb[2] = rand256();
        req_valid = 4'b0100;
        @(posedge clk);
        repeat (40) @(negedge clk);
        checkOutput("midrun_mul_start", mul_start, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_rst_start", mul_start, 0);
        checkOutput("midrun_rst_ain", mul_ain, 0);
        checkOutput("midrun_rst_bin", mul_bin, 0);
        checkOutput("midrun_rst_valid", rsp_valid, 0);
        checkOutput("midrun_rst_id", rsp_id, 0);
        checkOutput("midrun_rst_y", rsp_y, 0);
        checkOutput("midrun_rst_err", rsp_err, 0);
        checkOutput("midrun_rst_ready", req_ready, 0);
        req_valid = '0;
        model_ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        opa[1] = rand256();
        opb[1] = rand256();
        applyStimulus(4'b0110, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
